// File: rtl/decode_stage.sv
// Registered MIPS instruction-decode stage: valid/ready in and out, load-use
// interlock, flush, illegal-opcode flagging and saturating stall/issue counters.
module decode_stage #(
  parameter int PC_W     = 32,
  parameter int LU_DEPTH = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dst,
  output logic [31:0]      out_imm,
  output logic [25:0]      out_adr,
  output logic [3:0]       out_aluop,
  output logic             out_regwrite,
  output logic             out_memread,
  output logic             out_memwrite,
  output logic             out_immsel,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  localparam logic [2:0]       LU_LOAD = 3'(LU_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] src_rs;
  logic [4:0] src_rt;
  logic [3:0] dec_aluop;
  logic [4:0] dec_dst;
  logic       dec_regwrite;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_immsel;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_illegal;
  logic       reads_rt;
  logic       hazard;
  logic       handoff;
  logic       xfer;
  logic [2:0] ld_cnt;
  logic [4:0] ld_dst;

  assign opcode = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign src_rs = in_instr[25:21];
  assign src_rt = in_instr[20:16];

  always_comb begin
    dec_aluop    = ALU_ADD;
    dec_dst      = 5'd0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_immsel   = 1'b0;
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_regwrite = 1'b1;
        dec_dst      = in_instr[15:11];
        case (funct)
          6'h20, 6'h21: dec_aluop = ALU_ADD;
          6'h22:        dec_aluop = ALU_SUB;
          6'h24:        dec_aluop = ALU_AND;
          6'h25:        dec_aluop = ALU_OR;
          6'h2A:        dec_aluop = ALU_SLT;
          default: begin
            dec_illegal  = 1'b1;
            dec_regwrite = 1'b0;
            dec_dst      = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_immsel   = 1'b1;
        dec_regwrite = 1'b1;
        dec_dst      = src_rt;
      end
      OP_LW: begin
        dec_immsel   = 1'b1;
        dec_memread  = 1'b1;
        dec_regwrite = 1'b1;
        dec_dst      = src_rt;
      end
      OP_SW: begin
        dec_immsel   = 1'b1;
        dec_memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec_aluop  = ALU_SUB;
        dec_branch = 1'b1;
      end
      OP_J:    dec_jump    = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
    // Writing $0 is architecturally a no-op, so never request it.
    if (dec_dst == 5'd0) dec_regwrite = 1'b0;
  end

  assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign hazard   = (ld_cnt != 3'd0) && in_valid &&
                    ((src_rs == ld_dst) || ((src_rt == ld_dst) && reads_rt));
  assign handoff  = out_valid && out_ready;
  assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs       <= '0;
      out_rt       <= '0;
      out_dst      <= '0;
      out_imm      <= '0;
      out_adr      <= '0;
      out_aluop    <= '0;
      out_regwrite <= 1'b0;
      out_memread  <= 1'b0;
      out_memwrite <= 1'b0;
      out_immsel   <= 1'b0;
      out_branch   <= 1'b0;
      out_jump     <= 1'b0;
      out_illegal  <= 1'b0;
      ld_cnt       <= '0;
      ld_dst       <= '0;
      stall_cnt    <= '0;
      issue_cnt    <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (xfer) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_rs       <= src_rs;
        out_rt       <= src_rt;
        out_dst      <= dec_dst;
        out_imm      <= {{16{in_instr[15]}}, in_instr[15:0]};
        out_adr      <= in_instr[25:0];
        out_aluop    <= dec_aluop;
        out_regwrite <= dec_regwrite;
        out_memread  <= dec_memread;
        out_memwrite <= dec_memwrite;
        out_immsel   <= dec_immsel;
        out_branch   <= dec_branch;
        out_jump     <= dec_jump;
        out_illegal  <= dec_illegal;
      end else if (handoff) begin
        out_valid <= 1'b0;
      end

      // A fresh load leaving for execute re-arms the interlock window.
      if (flush) begin
        ld_cnt <= '0;
      end else if (handoff && out_memread && (out_dst != 5'd0)) begin
        ld_dst <= out_dst;
        ld_cnt <= LU_LOAD;
      end else if ((ld_cnt != 3'd0) && (out_ready || !out_valid)) begin
        ld_cnt <= ld_cnt - 3'd1;
      end

      if (handoff && (issue_cnt != '1)) issue_cnt <= issue_cnt + CNT_ONE;
      if (hazard && !flush && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (LU_DEPTH=1/CNT_W=16 and LU_DEPTH=3/CNT_W=2)
// share stimulus and are checked every cycle against a spec-level model.
module tb_decode_stage;
  localparam int PC_W = 32;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic [25:0] adr;
    logic [3:0]  aluop;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        immsel;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  localparam logic [31:0] ADD3   = 32'h00221820;
  localparam logic [31:0] LW5_4  = 32'h8C250004;
  localparam logic [31:0] ADD6   = 32'h00A23020;
  localparam logic [31:0] LW5_0  = 32'h8C250000;
  localparam logic [31:0] ADDI7  = 32'h2047FFFF;
  localparam logic [31:0] SW2    = 32'hAC220008;
  localparam logic [31:0] ADD9   = 32'h01084820;
  localparam logic [31:0] ILL_OP = 32'hFC000000;
  localparam logic [31:0] ILL_FN = 32'h0022183F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic inValid = 1'b0;
  logic flush = 1'b0;
  logic outReady = 1'b0;
  logic [31:0] inInstr = '0;
  logic [PC_W-1:0] inPc = '0;

  logic inReady [2];
  logic oValid [2];
  logic [PC_W-1:0] oPc [2];
  logic [4:0] oRs [2];
  logic [4:0] oRt [2];
  logic [4:0] oDst [2];
  logic [31:0] oImm [2];
  logic [25:0] oAdr [2];
  logic [3:0] oAlu [2];
  logic oRw [2];
  logic oMr [2];
  logic oMw [2];
  logic oIs [2];
  logic oBr [2];
  logic oJ [2];
  logic oIll [2];
  logic [15:0] stall0;
  logic [15:0] issue0;
  logic [1:0] stall1;
  logic [1:0] issue1;

  int checks = 0;
  int failures = 0;

  bundle_t mB [2];
  int mLd [2];
  logic [4:0] mLdDst [2];
  int mStall [2];
  int mIssue [2];
  int luDepth [2] = '{1, 3};
  int cntMax [2] = '{65535, 3};
  bit armed = 1'b0;
  bit justReset = 1'b0;

  decode_stage #(.PC_W(PC_W), .LU_DEPTH(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[0]), .in_instr(inInstr),
    .in_pc(inPc), .flush(flush), .out_valid(oValid[0]), .out_ready(outReady), .out_pc(oPc[0]),
    .out_rs(oRs[0]), .out_rt(oRt[0]), .out_dst(oDst[0]), .out_imm(oImm[0]), .out_adr(oAdr[0]),
    .out_aluop(oAlu[0]), .out_regwrite(oRw[0]), .out_memread(oMr[0]), .out_memwrite(oMw[0]),
    .out_immsel(oIs[0]), .out_branch(oBr[0]), .out_jump(oJ[0]), .out_illegal(oIll[0]),
    .stall_cnt(stall0), .issue_cnt(issue0)
  );

  decode_stage #(.PC_W(PC_W), .LU_DEPTH(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[1]), .in_instr(inInstr),
    .in_pc(inPc), .flush(flush), .out_valid(oValid[1]), .out_ready(outReady), .out_pc(oPc[1]),
    .out_rs(oRs[1]), .out_rt(oRt[1]), .out_dst(oDst[1]), .out_imm(oImm[1]), .out_adr(oAdr[1]),
    .out_aluop(oAlu[1]), .out_regwrite(oRw[1]), .out_memread(oMr[1]), .out_memwrite(oMw[1]),
    .out_immsel(oIs[1]), .out_branch(oBr[1]), .out_jump(oJ[1]), .out_illegal(oIll[1]),
    .stall_cnt(stall1), .issue_cnt(issue1)
  );

  // What the decode table says an instruction must turn into.
  function automatic bundle_t refDecode(logic [31:0] ins, logic [31:0] pc);
    bundle_t b;
    logic [5:0] op;
    logic [5:0] fn;
    b = '0;
    op = ins[31:26];
    fn = ins[5:0];
    b.valid = 1'b1;
    b.pc = pc;
    b.rs = ins[25:21];
    b.rt = ins[20:16];
    b.imm = {{16{ins[15]}}, ins[15:0]};
    b.adr = ins[25:0];
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) b.aluop = 4'd0;
      else if (fn == 6'h22) b.aluop = 4'd1;
      else if (fn == 6'h24) b.aluop = 4'd2;
      else if (fn == 6'h25) b.aluop = 4'd3;
      else if (fn == 6'h2A) b.aluop = 4'd4;
      else b.illegal = 1'b1;
      if (!b.illegal) begin
        b.regwrite = 1'b1;
        b.dst = ins[15:11];
      end
    end else if (op == 6'h08) begin
      b.immsel = 1'b1; b.regwrite = 1'b1; b.dst = ins[20:16];
    end else if (op == 6'h23) begin
      b.immsel = 1'b1; b.memread = 1'b1; b.regwrite = 1'b1; b.dst = ins[20:16];
    end else if (op == 6'h2B) begin
      b.immsel = 1'b1; b.memwrite = 1'b1;
    end else if (op == 6'h04) begin
      b.aluop = 4'd1; b.branch = 1'b1;
    end else if (op == 6'h02) begin
      b.jump = 1'b1;
    end else begin
      b.illegal = 1'b1;
    end
    if (b.dst == 5'd0) b.regwrite = 1'b0;
    return b;
  endfunction

  function automatic bit modelHazard(int i);
    logic [5:0] op;
    bit readsRt;
    op = inInstr[31:26];
    readsRt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return (mLd[i] != 0) && inValid &&
           ((inInstr[25:21] == mLdDst[i]) || ((inInstr[20:16] == mLdDst[i]) && readsRt));
  endfunction

  function automatic bundle_t dutBundle(int i);
    bundle_t b;
    b.valid = oValid[i]; b.pc = oPc[i]; b.rs = oRs[i]; b.rt = oRt[i]; b.dst = oDst[i];
    b.imm = oImm[i]; b.adr = oAdr[i]; b.aluop = oAlu[i]; b.regwrite = oRw[i];
    b.memread = oMr[i]; b.memwrite = oMw[i]; b.immsel = oIs[i]; b.branch = oBr[i];
    b.jump = oJ[i]; b.illegal = oIll[i];
    return b;
  endfunction

  task automatic checkOutput(string name, logic [127:0] actual, logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelCheck();
    bit expReady;
    if (!armed) return;
    for (int i = 0; i < 2; i++) begin
      expReady = !rst && !flush && !modelHazard(i) && (!mB[i].valid || outReady);
      checkOutput($sformatf("inReady%0d", i), 128'(inReady[i]), 128'(expReady));
      if (mB[i].valid || justReset)
        checkOutput($sformatf("bundle%0d", i), 128'(dutBundle(i)), 128'(mB[i]));
      else
        checkOutput($sformatf("outValid%0d", i), 128'(oValid[i]), 128'(1'b0));
    end
    checkOutput("stall0", 128'(stall0), 128'(mStall[0]));
    checkOutput("issue0", 128'(issue0), 128'(mIssue[0]));
    checkOutput("stall1", 128'(stall1), 128'(mStall[1]));
    checkOutput("issue1", 128'(issue1), 128'(mIssue[1]));
  endtask

  // Advance the model by one clock using the inputs currently presented.
  task automatic modelAdvance();
    bit handoff;
    bit xfer;
    bit haz;
    if (rst) begin
      armed = 1'b1;
      justReset = 1'b1;
      for (int i = 0; i < 2; i++) begin
        mB[i] = '0; mLd[i] = 0; mLdDst[i] = '0; mStall[i] = 0; mIssue[i] = 0;
      end
      return;
    end
    justReset = 1'b0;
    if (!armed) return;
    for (int i = 0; i < 2; i++) begin
      haz = modelHazard(i);
      handoff = mB[i].valid && outReady;
      xfer = inValid && !flush && !haz && (!mB[i].valid || outReady);
      if (handoff && mIssue[i] < cntMax[i]) mIssue[i]++;
      if (haz && !flush && mStall[i] < cntMax[i]) mStall[i]++;
      if (flush) mLd[i] = 0;
      else if (handoff && mB[i].memread && mB[i].dst != 5'd0) begin
        mLd[i] = luDepth[i];
        mLdDst[i] = mB[i].dst;
      end else if (mLd[i] > 0 && (outReady || !mB[i].valid)) mLd[i]--;
      if (flush) mB[i].valid = 1'b0;
      else if (xfer) mB[i] = refDecode(inInstr, inPc);
      else if (handoff) mB[i].valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(logic r, logic v, logic [31:0] ins, logic [31:0] pc,
                               logic ordy, logic fl);
    rst = r; inValid = v; inInstr = ins; inPc = pc; outReady = ordy; flush = fl;
    @(negedge clk);
    modelCheck();
  endtask

  task automatic endCycle();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(logic v, logic [31:0] ins, logic ordy, logic fl);
    applyStimulus(1'b0, v, ins, 32'h0040_0000 + 32'($urandom_range(0, 255) * 4), ordy, fl);
    endCycle();
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] fn;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: fn = 6'h20;
      1: fn = 6'h21;
      2: fn = 6'h22;
      3: fn = 6'h24;
      4: fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    case ($urandom_range(0, 11))
      0, 1: return {6'h00, rs, rt, rd, 5'd0, fn};
      2: return {6'h08, rs, rt, 16'($urandom)};
      3, 4, 5: return {6'h23, rs, rt, 16'($urandom)};
      6: return {6'h2B, rs, rt, 16'($urandom)};
      7: return {6'h04, rs, rt, 16'($urandom)};
      8: return {6'h02, 26'($urandom)};
      9: return {6'h3F, 26'($urandom)};
      10: return {6'h00, rs, rt, rd, 5'd0, 6'h3F};
      default: return {6'($urandom_range(9, 34)), 26'($urandom)};
    endcase
  endfunction

  initial begin
    // Reset and idle state.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    endCycle();
    applyStimulus(1'b1, 1'b1, ADD3, '0, 1'b1, 1'b0);
    checkOutput("rstInReady0", 128'(inReady[0]), 128'(1'b0));
    endCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("rstOutValid", 128'(oValid[0]), 128'(1'b0));
    checkOutput("rstIssue", 128'(issue0), 128'(0));
    checkOutput("idleInReady", 128'(inReady[0]), 128'(1'b1));
    endCycle();

    // Single add, latency one.
    cycle(1'b1, ADD3, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("addValid", 128'(oValid[0]), 128'(1'b1));
    checkOutput("addAlu", 128'(oAlu[0]), 128'(4'b0000));
    checkOutput("addDst", 128'(oDst[0]), 128'(5'd3));
    checkOutput("addRw", 128'(oRw[0]), 128'(1'b1));
    endCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("addIssue", 128'(issue0), 128'(1));
    endCycle();

    // Load-use: stall one cycle (LU_DEPTH=1) and three cycles (LU_DEPTH=3).
    cycle(1'b1, LW5_4, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, ADD6, 32'h100, 1'b1, 1'b0);
      checkOutput($sformatf("luReady0_%0d", k), 128'(inReady[0]), 128'(k >= 1));
      checkOutput($sformatf("luReady1_%0d", k), 128'(inReady[1]), 128'(k >= 3));
      endCycle();
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("luStall0", 128'(stall0), 128'(1));
    checkOutput("luStall1", 128'(stall1), 128'(3));
    endCycle();

    // Independent follower: no stall, negative immediate.
    cycle(1'b1, LW5_0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, ADDI7, 32'h200, 1'b1, 1'b0);
    checkOutput("addiReady", 128'(inReady[0]), 128'(1'b1));
    endCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("addiImm", 128'(oImm[0]), 128'(32'hFFFFFFFF));
    checkOutput("addiImmsel", 128'(oIs[0]), 128'(1'b1));
    checkOutput("addiDst", 128'(oDst[0]), 128'(5'd7));
    checkOutput("addiStall", 128'(stall0), 128'(1));
    endCycle();

    // Hold a store for four cycles, then release.
    applyStimulus(1'b0, 1'b1, SW2, 32'h300, 1'b1, 1'b0);
    endCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, ADD9, 32'h304, 1'b0, 1'b0);
      checkOutput("holdReady", 128'(inReady[0]), 128'(1'b0));
      checkOutput("holdMw", 128'(oMw[0]), 128'(1'b1));
      checkOutput("holdPc", 128'(oPc[0]), 128'(32'h300));
      endCycle();
    end
    applyStimulus(1'b0, 1'b1, ADD9, 32'h304, 1'b1, 1'b0);
    checkOutput("releaseReady", 128'(inReady[0]), 128'(1'b1));
    endCycle();

    // Flush a held bundle while fetch is offering another.
    applyStimulus(1'b0, 1'b1, ADD3, 32'h308, 1'b0, 1'b1);
    checkOutput("flushHeldDst", 128'(oDst[0]), 128'(5'd9));
    checkOutput("flushReady", 128'(inReady[0]), 128'(1'b0));
    endCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("flushValid", 128'(oValid[0]), 128'(1'b0));
    endCycle();
    cycle(1'b1, LW5_4, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, ADD6, 32'h400, 1'b1, 1'b0);
    checkOutput("flushLdClr", 128'(inReady[1]), 128'(1'b1));
    endCycle();
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Illegal opcode and illegal funct.
    cycle(1'b1, ILL_OP, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, ILL_FN, 32'h500, 1'b1, 1'b0);
    checkOutput("illOp", 128'(oIll[0]), 128'(1'b1));
    checkOutput("illOpEn", 128'({oRw[0], oMr[0], oMw[0]}), 128'(3'b000));
    endCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("illFn", 128'(oIll[0]), 128'(1'b1));
    checkOutput("illFnEn", 128'({oRw[0], oMr[0], oMw[0]}), 128'(3'b000));
    endCycle();

    // Randomised traffic including occasional flush and reset.
    for (int n = 0; n < 4000; n++) begin
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), randInstr(),
                    $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      endCycle();
    end
    for (int n = 0; n < 20; n++) cycle(1'b1, ADD9, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("satIssue1", 128'(issue1), 128'(2'd3));
    endCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
